// File: rtl/seven_segment_mux.sv
// Multiplexed seven-segment controller: hex/BCD value register scanned onto one shared segment bus; seg/an registered (1-cycle display latency), no backpressure.
// Optional leading-zero blanking when SEVSEG_LZB_EN is defined.
module seven_segment_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter bit BCD      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  inc,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  ovf
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] WRAP = BCD ? 4'd9 : 4'hF;

  logic [4*DIGITS-1:0] value;
  logic [4*DIGITS-1:0] value_inc;
  logic                carry_out;
  logic [CW-1:0]       scan_cnt;
  logic [IW-1:0]       idx;
  logic                scan_last;
  logic [IW-1:0]       idx_next;
  logic [3:0]          cur_nib;
  logic                blank;

  // Lit-segment pattern, bit 0 = a ... bit 6 = g
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // Ripple carry; a BCD nibble loaded above 9 still wraps on the next increment
  always_comb begin : incr
    logic c;
    c         = 1'b1;
    value_inc = value;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (value[4*k +: 4] >= WRAP) begin
          value_inc[4*k +: 4] = 4'd0;
        end else begin
          value_inc[4*k +: 4] = value[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    carry_out = c;
  end

  assign scan_last = (scan_cnt == CW'(SCAN_DIV - 1));
  assign idx_next  = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
  assign cur_nib   = value[idx*4 +: 4];

`ifdef SEVSEG_LZB_EN
  always_comb begin : lzb
    logic allz;
    allz  = 1'b1;
    blank = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      allz = allz & (value[4*k +: 4] == 4'd0);
      if (idx == IW'(k) && allz) blank = 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      value    <= '0;
      ovf      <= 1'b0;
      scan_cnt <= '0;
      idx      <= '0;
      an       <= '1;
      seg      <= 7'h7F;
    end else begin
      if (load)     value <= din;
      else if (inc) value <= value_inc;
      ovf <= inc & ~load & carry_out;

      scan_cnt <= scan_last ? '0 : scan_cnt + 1'b1;
      if (scan_last) idx <= idx_next;

      // an and seg share one edge so a new digit never shows the previous glyph
      if (blank) begin
        an  <= '1;
        seg <= 7'h7F;
      end else begin
        an  <= ~(DIGITS'(1) << idx);
        seg <= ~glyph(cur_nib);
      end
    end
  end

endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Parametrised multiplexed seven-segment display controller and successor to the single-digit counter/decoder. Holds a DIGITS-wide value register that is loadable and incrementable in hex or BCD, and time-multiplexes its digits onto one shared segment bus with one-hot digit enables. It sits between user logic (counters, debug registers) and the board's common-anode display.

## Interface
- DIGITS, 4: number of display digits, 1..8.
- SCAN_DIV, 1000: clk cycles each digit is driven, ≥2.
- BCD, 0: 0 = hex counting (digit wraps F→0); 1 = decimal counting (digit wraps 9→0).

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  when high, value register ← din at next edge.
- din  in  4*DIGITS  load data; nibble k = digit k (digit 0 least significant).
- inc  in  1  when high (and load low), value register increments by 1 at next edge.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- an  out  DIGITS  digit enables, active-low, at most one low.
- ovf  out  1  one-cycle pulse when an increment wraps the full value to zero.

## Operation
- Value register: DIGITS nibbles. Priority: rst > load > inc > hold.
- Increment ripples a carry from digit 0. Wrap point per digit: hex F, BCD 9. A digit at wrap becomes 0 and passes the carry on.
- If the carry leaves digit DIGITS-1, ovf = 1 for the next cycle.
- Loaded nibbles >9 in BCD mode display as hex. On increment, a BCD nibble ≥9 wraps to 0 with carry.
- Scan counter counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the digit index advances (DIGITS-1 → 0).
- Decoder, hex glyph to lit segments:
  - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg
  - 4 bcfg; 5 acdfg; 6 acdefg; 7 abc
  - 8 abcdefg; 9 abcdfg; A abcefg; b cdefg
  - C adef; d bcdeg; E adefg; F aefg
- seg and an are registered every cycle from the current digit index and the current value register.
  - an = ~(1 << index).
  - seg = ~glyph(nibble[index]).
- DIGITS=1: index stays 0 and the scan counter still runs.

## Timing
- Reset values: value 0, index 0, scan count 0, ovf 0, an all 1s, seg 7'h7F (all dark).
- First edge after rst falls: an = ~1, seg = glyph 0 (7'h40).
- load/inc → value updated at edge N. seg reflects it at edge N+1 if that digit is selected (one-cycle display latency).
- ovf is asserted the cycle after the wrapping increment edge, for exactly one cycle.
- Digit advances every SCAN_DIV cycles, so a full refresh takes DIGITS*SCAN_DIV cycles. an and seg change on the same edge, so the bus never shows a stale glyph on a new digit.
- load and inc together: load wins; no ovf.
- rst mid-scan or mid-increment: everything returns to reset values on that edge; a pending ovf is dropped.
- inc held high: increments every cycle.

## Configuration
- SEVSEG_LZB_EN defined: leading-zero blanking. Any digit k>0 with all nibbles k..DIGITS-1 zero is blanked while selected: an stays high and seg = 7'h7F. Digit 0 is never blanked. Scan timing is unchanged.
- SEVSEG_LZB_EN undefined: every digit is always displayed, including leading zeros.

## Test plan
- Reset, DIGITS=4, SCAN_DIV=4: first edge after release shows an=4'b1110, seg=7'h40. an steps 1110→1101→1011→0111→1110 every 4 cycles.
- Load din=16'h12AF, hex: over one refresh, seg shows F=7'h0E, A=7'h08, 2=7'h24, 1=7'h79 on digits 0..3 respectively.
- Load 16'hFFFF, pulse inc: value becomes 0000 and ovf is high for exactly one cycle. Assert load and inc together with din=16'h0005: value is 0005 and ovf stays 0.
- BCD=1, load 16'h0099, inc: value 0100. Load 16'h9999, inc: value 0000 with an ovf pulse.
- Assert rst during scan index 2 with inc held high: next edge shows an all 1s, seg 7'h7F, value 0. Digit 0 resumes after release.
- SEVSEG_LZB_EN defined, value 16'h0030: digits 3 and 2 dark (an high). Digits 1 and 0 show 3 and 0. With value 0, only digit 0 is lit, showing 0.
